demux_1_to_16_buf: RTL and testbench
====================================

Name: demux_1_to_16_buf

Overview:
- Buffered 1-to-16 demultiplexer: the write-side counterpart of the 16-to-1 read mux.
- Accepts one N-bit word per handshake and steers it into one of 16 holding lanes.
- Lane is chosen either by an explicit select or by an internal auto-incrementing scan pointer.
- Each lane holds its word and a full flag until the downstream consumer acknowledges it; the upstream is back-pressured while the target lane is full.

Parameters:
N, 8, data width of the input word and of each output lane

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_data  input  N  word to distribute
in_valid  input  1  in_data is presented this cycle
in_ready  output  1  target lane can accept; combinational = ~full[target]
Sel  input  4  target lane index when auto_inc = 0
auto_inc  input  1  1: target = scan_ptr; 0: target = Sel
out_flat  output  16*N  lane i data at bits [i*N +: N], registered
out_full  output  16  out_full[i] = lane i holds unacknowledged data
out_ack  input  16  out_ack[i] = consumer takes lane i this cycle
scan_ptr  output  4  current auto-increment pointer, registered

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - out_flat = 0, out_full = 0, scan_ptr = 0.
  - in_ready therefore = 1 in the following cycle.
  - Reset overrides any in_valid or out_ack in the same cycle, including a reset that arrives mid-stream.
- Target selection: target = auto_inc ? scan_ptr : Sel. This is combinational; there is no registered copy of Sel.
- Accept condition: accept = in_valid & in_ready, evaluated from the registered out_full only (no same-cycle bypass).
- On accept:
  - Lane[target] data <= in_data and out_full[target] <= 1 at the same edge; visible 1 cycle after the handshake.
  - All other lanes are unchanged.
- No accept: no lane changes; in_data is ignored; in_valid may be held high indefinitely while in_ready = 0.
- Ack:
  - out_ack[i] with out_full[i] = 1 clears out_full[i] at the next edge.
  - out_ack[i] with out_full[i] = 0 is ignored.
  - Lane data is NOT cleared by ack; the last written value stays on out_flat.
- Ack and write in the same cycle:
  - Same lane: the lane is full, so in_ready = 0 and the write is refused; the ack clears the flag. The write succeeds one cycle later at the earliest.
  - Different lanes: both take effect independently at the same edge.
  - Multiple out_ack bits may be high together; all are honoured.
- scan_ptr:
  - Increments by 1 on each accept while auto_inc = 1, wrapping 15 -> 0 (4-bit modulo).
  - Holds when auto_inc = 0, when there is no accept, or when the target is full.
  - Switching auto_inc mid-stream neither resets nor moves scan_ptr.
- Throughput: 1 word/cycle while target lanes are empty.
- Latency: handshake to out_full/out_flat update = 1 cycle. The block has no internal state machine beyond the per-lane full flags and scan_ptr.
- in_ready depends on Sel/auto_inc combinationally; upstream must hold Sel stable while in_valid is high.

Decomposition:
- Shared package/header holds constants LANES = 16 and SEL_W = 4.
- One sub-module, demux_lane: a single N-bit holding register plus full flag.
  - Inputs: clk, rst_n, wr_en, wr_data, ack.
  - Outputs: data, full.
  - Instantiated 16 times via generate, with wr_en[i] = accept & (target == i).
- The top level contains target selection, scan_ptr, in_ready, and out_flat packing.

Test Plan:
1. Reset, then auto_inc = 0, Sel = 5, in_valid = 1, in_data = 0xA5 for 1 cycle -> next cycle out_full = 0x0020, lane 5 = 0xA5, every other lane 0x00, scan_ptr = 0.
2. With lane 5 still full, Sel = 5, in_data = 0x3C, in_valid held -> in_ready = 0 and lane 5 stays 0xA5. Assert out_ack[5] for 1 cycle -> the write is accepted the cycle after the flag clears; lane 5 = 0x3C, out_full[5] = 1 again.
3. auto_inc = 1, 17 consecutive writes of 0x00..0x10 with all lanes acked each cycle after fill -> lanes 0..15 get 0x00..0x0F, then lane 0 gets 0x10; scan_ptr sequence 0..15, 0, 1.
4. auto_inc = 1, all lanes full, in_valid = 1 -> in_ready = 0 and scan_ptr frozen. Ack lane 3 only while scan_ptr = 3 -> exactly one write lands in lane 3, scan_ptr = 4.
5. Same cycle: out_ack[2] = 1 on full lane 2 while writing Sel = 9 (empty), in_data = 0x77 -> next cycle out_full[2] = 0, out_full[9] = 1, lane 9 = 0x77, lane 2 data unchanged.
6. Mid-stream: 6 lanes full, scan_ptr = 6, rst_n = 0 for 1 cycle together with in_valid = 1 -> out_flat = 0, out_full = 0, scan_ptr = 0, no write taken.

Source files
------------

// File: rtl/demux_1_to_16_buf_pkg.sv
// rtl/demux_1_to_16_buf_pkg.sv - shared constants, types and helpers for the 1-to-16 buffered demux
package demux_1_to_16_buf_pkg;

  // Number of holding lanes and the width of a lane index.
  localparam int LANES = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] lane_idx_t;
  typedef logic [LANES-1:0] lane_mask_t;

  // One-hot mask selecting a single lane.
  function automatic lane_mask_t lane_onehot(input lane_idx_t idx);
    lane_onehot = lane_mask_t'(1) << idx;
  endfunction

  // Scan pointer advance; the 4-bit width gives the 15 -> 0 wrap for free.
  function automatic lane_idx_t next_ptr(input lane_idx_t ptr);
    next_ptr = ptr + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/demux_1_to_16_buf_if.sv
// rtl/demux_1_to_16_buf_if.sv - upstream write port and downstream lane bus of the 1-to-16 demux
interface demux_1_to_16_buf_if #(
  parameter int N = 8
);
  import demux_1_to_16_buf_pkg::*;

  // Upstream word handshake and lane selection.
  logic [N-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  lane_idx_t          Sel;
  logic               auto_inc;

  // Downstream lane contents, occupancy and per-lane acknowledge.
  logic [LANES*N-1:0] out_flat;
  lane_mask_t         out_full;
  lane_mask_t         out_ack;
  lane_idx_t          scan_ptr;

  // Producer/consumer side, seen from outside the demux.
  modport master (
    output in_data,
    output in_valid,
    output Sel,
    output auto_inc,
    output out_ack,
    input  in_ready,
    input  out_flat,
    input  out_full,
    input  scan_ptr
  );

  // The demux itself.
  modport slave (
    input  in_data,
    input  in_valid,
    input  Sel,
    input  auto_inc,
    input  out_ack,
    output in_ready,
    output out_flat,
    output out_full,
    output scan_ptr
  );

endinterface

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - one holding lane: N-bit data register plus full flag
module demux_lane #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         ack,
  output logic [N-1:0] data,
  output logic         full
);

  // Data is only overwritten by a write; ack leaves the last word visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr_en) begin
      data <= wr_data;
    end
  end

  // Write sets the flag, ack of a held word clears it; ack on an empty lane is a no-op.
  // wr_en is only raised for an empty lane, so write and ack never collide here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (ack && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_16_buf.sv
// rtl/demux_1_to_16_buf.sv - buffered 1-to-16 demux with explicit or auto-increment lane select
module demux_1_to_16_buf
  import demux_1_to_16_buf_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_1_to_16_buf_if.slave bus
);

  lane_idx_t                 scan_ptr_q;
  lane_idx_t                 target;
  lane_mask_t                full_vec;
  lane_mask_t                wr_en;
  logic                      accept;
  logic [LANES-1:0][N-1:0]   lane_data;

  // Target lane is picked combinationally; Sel is never registered.
  always_comb begin
    target = scan_ptr_q;
    if (!bus.auto_inc) begin
      target = bus.Sel;
    end
  end

  // Ready only looks at the registered full flags, so an ack this cycle
  // cannot open the lane for a write in the same cycle.
  assign bus.in_ready = ~full_vec[target];
  assign accept       = bus.in_valid & bus.in_ready;
  assign wr_en        = accept ? lane_onehot(target) : '0;

  // Scan pointer moves only on an accepted auto-increment write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_ptr_q <= '0;
    end else if (accept && bus.auto_inc) begin
      scan_ptr_q <= next_ptr(scan_ptr_q);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane #(
      .N(N)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[i]),
      .wr_data(bus.in_data),
      .ack    (bus.out_ack[i]),
      .data   (lane_data[i]),
      .full   (full_vec[i])
    );
  end

  // Packed lane array flattens with lane i at bits [i*N +: N].
  assign bus.out_flat = lane_data;
  assign bus.out_full = full_vec;
  assign bus.scan_ptr = scan_ptr_q;

endmodule

// File: tb/tb_demux_1_to_16_buf.sv
// tb/tb_demux_1_to_16_buf.sv - self-checking bench for demux_1_to_16_buf
module tb_demux_1_to_16_buf;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1_to_16_buf_if #(.N(N)) bus ();

  demux_1_to_16_buf #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: lane contents, occupancy and scan position.
  logic [N-1:0] m_data [16];
  bit           m_full [16];
  int           m_ptr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_full_vec();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_full[i];
    return r;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*N +: N] = m_data[i];
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_data[i] = '0;
      m_full[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [N-1:0] lane(input int i);
    logic [127:0] f;
    f = bus.out_flat;
    return f[i*N +: N];
  endfunction

  // One clock of stimulus, checked against the model before and after the edge.
  task automatic cyc(input bit rstn, input bit valid, input bit auto, input int sel,
                     input logic [N-1:0] data, input logic [15:0] ack);
    int t;
    bit acc;
    rst_n        = rstn;
    bus.in_valid = valid;
    bus.auto_inc = auto;
    bus.Sel      = 4'(sel);
    bus.in_data  = data;
    bus.out_ack  = ack;
    #1;
    t = auto ? m_ptr : sel;
    chk("in_ready", 128'(bus.in_ready), 128'(!m_full[t]));
    acc = valid && !m_full[t];
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_clear();
    end else begin
      for (int i = 0; i < 16; i++) if (ack[i]) m_full[i] = 1'b0;
      if (acc) begin
        m_data[t] = data;
        m_full[t] = 1'b1;
        if (auto) m_ptr = (m_ptr + 1) % 16;
      end
    end
    chk("out_full", 128'(bus.out_full), 128'(m_full_vec()));
    chk("out_flat", bus.out_flat, m_flat());
    chk("scan_ptr", 128'(bus.scan_ptr), 128'(m_ptr));
  endtask

  initial begin
    m_clear();
    bus.in_valid = 1'b0;
    bus.auto_inc = 1'b0;
    bus.Sel      = '0;
    bus.in_data  = '0;
    bus.out_ack  = '0;

    // Reset state
    cyc(0, 0, 0, 0, 8'h00, 16'h0);
    cyc(0, 1, 1, 3, 8'hFF, 16'hFFFF);
    chk("rst_full", 128'(bus.out_full), 128'h0);
    chk("rst_flat", bus.out_flat, 128'h0);
    chk("rst_ready", 128'(bus.in_ready), 128'h1);

    // 1: single explicit write to lane 5
    cyc(1, 1, 0, 5, 8'hA5, 16'h0);
    chk("t1_full", 128'(bus.out_full), 128'h0020);
    chk("t1_lane5", 128'(lane(5)), 128'hA5);
    chk("t1_lane4", 128'(lane(4)), 128'h00);
    chk("t1_ptr", 128'(bus.scan_ptr), 128'h0);

    // 2: back-pressure on full lane, ack, then the write lands a cycle later
    cyc(1, 1, 0, 5, 8'h3C, 16'h0);
    cyc(1, 1, 0, 5, 8'h3C, 16'h0);
    chk("t2_hold", 128'(lane(5)), 128'hA5);
    cyc(1, 1, 0, 5, 8'h3C, 16'h0020);
    chk("t2_cleared", 128'(bus.out_full), 128'h0);
    chk("t2_kept", 128'(lane(5)), 128'hA5);
    cyc(1, 1, 0, 5, 8'h3C, 16'h0);
    chk("t2_lane5", 128'(lane(5)), 128'h3C);
    chk("t2_full", 128'(bus.out_full), 128'h0020);
    cyc(1, 0, 0, 0, 8'h00, 16'hFFFF);

    // 3: 17 auto-increment writes with everything acked each cycle
    for (int k = 0; k < 17; k++) begin
      cyc(1, 1, 1, 0, 8'(k), 16'hFFFF);
      chk("t3_ptr", 128'(bus.scan_ptr), 128'((k + 1) % 16));
    end
    chk("t3_lane0", 128'(lane(0)), 128'h10);
    chk("t3_lane15", 128'(lane(15)), 128'h0F);
    chk("t3_lane7", 128'(lane(7)), 128'h07);

    // 4: fill every lane, park scan_ptr at 3, then free only lane 3
    cyc(1, 0, 1, 0, 8'h00, 16'hFFFF);
    for (int k = 0; k < 16; k++) cyc(1, 1, 1, 0, 8'(8'h40 + k), 16'h0);
    cyc(1, 0, 1, 0, 8'h00, 16'h0006);
    cyc(1, 1, 1, 0, 8'h51, 16'h0);
    cyc(1, 1, 1, 0, 8'h52, 16'h0);
    chk("t4_allfull", 128'(bus.out_full), 128'hFFFF);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 0, 8'hEE, 16'h0);
    chk("t4_frozen", 128'(bus.scan_ptr), 128'h3);
    cyc(1, 1, 1, 0, 8'hE3, 16'h0008);
    cyc(1, 1, 1, 0, 8'hE3, 16'h0);
    chk("t4_lane3", 128'(lane(3)), 128'hE3);
    chk("t4_ptr", 128'(bus.scan_ptr), 128'h4);
    cyc(1, 1, 1, 0, 8'hE4, 16'h0);
    chk("t4_ptr_hold", 128'(bus.scan_ptr), 128'h4);

    // 5: ack on one lane and write to another in the same cycle
    cyc(1, 0, 0, 0, 8'h00, 16'hFFFF);
    cyc(1, 1, 0, 2, 8'h22, 16'h0);
    cyc(1, 1, 0, 9, 8'h77, 16'h0004);
    chk("t5_full", 128'(bus.out_full), 128'h0200);
    chk("t5_lane9", 128'(lane(9)), 128'h77);
    chk("t5_lane2", 128'(lane(2)), 128'h22);

    // 6: reset mid-stream overrides a pending write
    cyc(0, 0, 0, 0, 8'h00, 16'h0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 1, 0, 8'(8'h60 + k), 16'h0);
    chk("t6_ptr6", 128'(bus.scan_ptr), 128'h6);
    cyc(0, 1, 1, 0, 8'hFF, 16'h0);
    chk("t6_full", 128'(bus.out_full), 128'h0);
    chk("t6_flat", bus.out_flat, 128'h0);
    chk("t6_ptr", 128'(bus.scan_ptr), 128'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 60) != 0, ($urandom % 4) != 0, $urandom % 2,
          int'($urandom_range(0, 15)), 8'($urandom), 16'($urandom & $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
